// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator and its saturating adder.
// Combinational constants only; no latency or backpressure of its own.
package prod_acc_pkg;

    localparam int PW_DEF = 16;
    localparam int AW_DEF = 20;
    localparam int LW_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AW_DEF-1:0] SAT_MAX = {1'b0, {(AW_DEF-1){1'b1}}};
    localparam logic [AW_DEF-1:0] SAT_MIN = {1'b1, {(AW_DEF-1){1'b0}}};

endpackage

// File: rtl/prod_accumulator_if.sv
// Product-in / result-out bundle between the Booth multiplier, accumulator and consumer.
// Both data paths are valid/ready; the master side drives run control and accepts results.
import prod_acc_pkg::*;

interface prod_acc_if #(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
);
    logic          start;
    logic [LW-1:0] len;
    logic          prod_valid;
    logic [PW-1:0] prod_in;
    logic          prod_ready;
    logic          acc_valid;
    logic [AW-1:0] acc_out;
    logic          acc_ready;
    logic          ovf;
    logic          busy;

    modport master (
        output start, len, prod_valid, prod_in, acc_ready,
        input  prod_ready, acc_valid, acc_out, ovf, busy
    );

    modport slave (
        input  start, len, prod_valid, prod_in, acc_ready,
        output prod_ready, acc_valid, acc_out, ovf, busy
    );
endinterface

// File: rtl/prod_accumulator_sat_add.sv
// Signed AW + sign-extended PW adder clamped to the AW-bit range, with overflow flag.
// Purely combinational: zero latency, no backpressure.
import prod_acc_pkg::*;

module sat_add #(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] i_a,
    input  logic [PW-1:0] i_b,
    output logic [AW-1:0] o_sum,
    output logic          o_ovf
);
    localparam logic [AW-1:0] L_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] L_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW:0] w_full;

    // One guard bit is enough: |i_b| is far below 2^(AW-1), so the true sum fits in AW+1 bits.
    assign w_full = {i_a[AW-1], i_a} + {{(AW+1-PW){i_b[PW-1]}}, i_b};

    always_comb begin
        o_sum = w_full[AW-1:0];
        o_ovf = 1'b0;
        if (w_full[AW] != w_full[AW-1]) begin
            o_ovf = 1'b1;
            o_sum = w_full[AW] ? L_MIN : L_MAX;
        end
    end
endmodule

// File: rtl/prod_accumulator.sv
// Sums LEN signed products into one saturating result; result valid the cycle after the last product.
// Products accepted every ACCUM cycle (prod_ready from state); result held in DONE until acc_ready.
import prod_acc_pkg::*;

module prod_accumulator #(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    prod_acc_if.slave   bus
);
    state_t        r_state;
    logic [AW-1:0] r_acc;
    logic [LW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_acc_valid;
    logic          r_busy;

    logic [AW-1:0] w_sum;
    logic          w_sum_ovf;
    logic          w_prod_ready;

    sat_add #(
        .PW (PW),
        .AW (AW)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (bus.prod_in),
        .o_sum (w_sum),
        .o_ovf (w_sum_ovf)
    );

    assign w_prod_ready = (r_state == S_ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_acc_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_cnt   <= bus.len;
                            r_state <= S_ACCUM;
                        end else begin
                            r_acc_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.prod_valid) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_sum_ovf;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == LW'(1)) begin
                            r_acc_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // ovf deliberately survives the return to IDLE; only a new start clears it.
                    if (bus.acc_ready) begin
                        r_acc_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_acc_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.prod_ready = w_prod_ready;
    assign bus.acc_valid  = r_acc_valid;
    assign bus.acc_out    = r_acc;
    assign bus.ovf        = r_ovf;
    assign bus.busy       = r_busy;

endmodule
